// File: rtl/bit_scan_pkg.sv
// Shared types and constants for the bit-scan iterator.
package bit_scan_pkg;

    // Scan direction, captured per transaction
    localparam logic SCAN_MSB_FIRST = 1'b0;
    localparam logic SCAN_LSB_FIRST = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    // Beat counter must hold 0..WIDTH-1 with one spare bit of headroom
    function automatic int calc_seq_w(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/prio_enc_param.sv
// Combinational priority encoder: highest or lowest set bit of vec.
module prio_enc_param
    import bit_scan_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    input  logic             dir,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             onehot_or_zero
);

    // Last match in loop order wins, so loop direction picks the priority
    always_comb begin
        idx = '0;
        if (dir == SCAN_MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero iff at most one bit was set
    always_comb begin
        any            = |vec;
        onehot_or_zero = ((vec & (vec - WIDTH'(1))) == '0);
    end

endmodule

// File: rtl/bit_scan_iter.sv
// Walks a WIDTH-bit mask, emitting one set-bit index per output handshake.
module bit_scan_iter
    import bit_scan_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int IDX_W = $clog2(WIDTH),
    localparam int SEQ_W = calc_seq_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             in_lsb_first,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [IDX_W-1:0] out_idx,
    output logic [SEQ_W-1:0] out_seq,
    output logic             out_last,
    output logic             out_zero,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] residual_q, residual_d;
    logic             dir_q, dir_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             zero_q, zero_d;

    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             enc_single;
    logic             fire;
    logic             accept;
    logic [WIDTH-1:0] clr_mask;

    prio_enc_param #(.WIDTH(WIDTH)) u_enc (
        .vec            (residual_q),
        .dir            (dir_q),
        .idx            (enc_idx),
        .any            (enc_any),
        .onehot_or_zero (enc_single)
    );

    // Output decode; in_rdy also opens on the final beat for zero-bubble reload
    always_comb begin
        out_vld  = (state_q == SCAN);
        out_idx  = enc_any ? enc_idx : '0;
        out_last = zero_q | enc_single;
        out_zero = zero_q;
        out_seq  = seq_q;
        busy     = (state_q == SCAN);
        fire     = out_vld & out_rdy;
        in_rdy   = !rst && !flush && ((state_q == IDLE) || (fire && out_last));
        accept   = in_vld & in_rdy;
    end

    // Next state: flush beats accept, accept beats the plain end-of-scan
    always_comb begin
        state_d    = state_q;
        residual_d = residual_q;
        dir_d      = dir_q;
        seq_d      = seq_q;
        zero_d     = zero_q;
        clr_mask   = '0;
        clr_mask[enc_idx] = 1'b1;
        if (flush) begin
            state_d    = IDLE;
            residual_d = '0;
        end else if (accept) begin
            state_d    = SCAN;
            residual_d = in_vec;
            dir_d      = in_lsb_first;
            seq_d      = '0;
            zero_d     = (in_vec == '0);
        end else if (fire && out_last) begin
            state_d    = IDLE;
            residual_d = '0;
        end else if (fire) begin
            residual_d = residual_q & ~clr_mask;
            seq_d      = seq_q + SEQ_W'(1);
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            residual_q <= '0;
            dir_q      <= SCAN_MSB_FIRST;
            seq_q      <= '0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            residual_q <= residual_d;
            dir_q      <= dir_d;
            seq_q      <= seq_d;
            zero_q     <= zero_d;
        end
    end

endmodule

// File: tb/tb_bit_scan_iter.sv
// Scoreboard bench for bit_scan_iter at WIDTH=32.
module tb_bit_scan_iter;

    localparam int W = 32;

    typedef struct {
        int idx;
        int seq;
        bit last;
        bit zero;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_vld = 1'b0;
    logic         in_rdy;
    logic [W-1:0] in_vec = '0;
    logic         in_lsb_first = 1'b0;
    logic         out_vld;
    logic         out_rdy = 1'b1;
    logic [4:0]   out_idx;
    logic [5:0]   out_seq;
    logic         out_last;
    logic         out_zero;
    logic         busy;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    rdy_mode = 0;
    beat_t q[$];
    beat_t mon_e;

    bit_scan_iter #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_vld       (in_vld),
        .in_rdy       (in_rdy),
        .in_vec       (in_vec),
        .in_lsb_first (in_lsb_first),
        .out_vld      (out_vld),
        .out_rdy      (out_rdy),
        .out_idx      (out_idx),
        .out_seq      (out_seq),
        .out_last     (out_last),
        .out_zero     (out_zero),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: list every set bit in scan order
    task automatic push_expect(input logic [W-1:0] v, input logic lsb);
        int cnt = 0;
        int n = 0;
        beat_t b;
        for (int i = 0; i < W; i++) cnt += int'(v[i]);
        if (cnt == 0) begin
            b = '{idx: 0, seq: 0, last: 1'b1, zero: 1'b1};
            q.push_back(b);
        end else begin
            for (int k = 0; k < W; k++) begin
                int i;
                i = lsb ? k : (W - 1 - k);
                if (v[i]) begin
                    b = '{idx: i, seq: n, last: (n == cnt - 1), zero: 1'b0};
                    q.push_back(b);
                    n++;
                end
            end
        end
    endtask

    // Drive one vector; returns at posedge+1 after accept
    task automatic send(input logic [W-1:0] v, input logic lsb);
        int  n = 0;
        bit  acc = 0;
        in_vec = v;
        in_lsb_first = lsb;
        in_vld = 1'b1;
        do begin
            @(negedge clk);
            acc = in_rdy;
            @(posedge clk);
            n++;
        end while (!acc && n < 200);
        if (acc) push_expect(v, lsb);
        #1;
        in_vld = 1'b0;
        in_vec = $urandom;
        in_lsb_first = $urandom_range(0, 1);
        if (!acc) chk("accept_timeout", {31'b0, in_rdy}, 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", q.size(), 0);
    endtask

    // Consumer ready pattern: always, alternating, or random
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            1:       out_rdy = ~out_rdy;
            2:       out_rdy = 1'($urandom_range(0, 1));
            default: out_rdy = 1'b1;
        endcase
    end

    // Monitor: every valid cycle matches the queue head; pop on handshake
    always @(negedge clk) begin
        if (rst || flush) begin
            q.delete();
        end else begin
            chk("out_vld", {31'b0, out_vld}, {31'b0, q.size() > 0});
            chk("busy", {31'b0, busy}, {31'b0, q.size() > 0});
            if (out_vld && q.size() > 0) begin
                mon_e = q[0];
                chk("out_idx", {27'b0, out_idx}, mon_e.idx);
                chk("out_seq", {26'b0, out_seq}, mon_e.seq);
                chk("out_last", {31'b0, out_last}, {31'b0, mon_e.last});
                chk("out_zero", {31'b0, out_zero}, {31'b0, mon_e.zero});
                if (out_rdy) begin
                    void'(q.pop_front());
                    if (mon_e.last) chk("in_rdy_on_last", {31'b0, in_rdy}, 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_rdy", {31'b0, in_rdy}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_vld", {31'b0, out_vld}, 32'd0);
        chk("post_rst_busy", {31'b0, busy}, 32'd0);
        chk("post_rst_in_rdy", {31'b0, in_rdy}, 32'd1);
        chk("post_rst_seq", {26'b0, out_seq}, 32'd0);
        chk("post_rst_zero", {31'b0, out_zero}, 32'd0);
        @(posedge clk);
        #1;

        // Ends of the word in both orders, then the all-zero vector
        send(32'h8000_0001, 1'b0); drain();
        send(32'h8000_0001, 1'b1); drain();
        send(32'h0000_0000, 1'b0); drain();

        // Full vector under alternating backpressure
        rdy_mode = 1;
        send(32'hFFFF_FFFF, 1'b0); drain();
        rdy_mode = 0;

        // Back-to-back with zero bubble
        send(32'h0000_0030, 1'b0);
        send(32'h0000_0100, 1'b0);
        drain();

        // Single-bit boundaries
        send(32'h0000_0001, 1'b0); drain();
        send(32'h8000_0000, 1'b1); drain();

        // Flush after the first beat
        send(32'h0F00_0000, 1'b0);
        @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("flush_in_rdy", {31'b0, in_rdy}, 32'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_vld", {31'b0, out_vld}, 32'd0);
        chk("flush_in_rdy_after", {31'b0, in_rdy}, 32'd1);
        @(posedge clk);
        #1;
        send(32'h0000_0002, 1'b0); drain();

        // Reset in mid-scan
        send(32'hFFFF_0000, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_rdy", {31'b0, in_rdy}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_vld", {31'b0, out_vld}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_in_rdy", {31'b0, in_rdy}, 32'd1);
        @(posedge clk);
        #1;
        send(32'h0000_0002, 1'b0); drain();

        // Random vectors under random backpressure, some back-to-back
        rdy_mode = 2;
        for (int t = 0; t < 12; t++) begin
            logic [W-1:0] v;
            v = $urandom;
            if (t % 4 == 1) v = v & (v >> 7) & (v >> 13);
            send(v, 1'($urandom_range(0, 1)));
            if (t % 3 == 2) drain();
        end
        drain();
        rdy_mode = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_scan_iter.md
Name: bit_scan_iter

Overview:
- Parametrised, sequential successor to the team's fixed 32-to-5 leading-one encoder.
- Accepts one WIDTH-bit vector per transaction and emits the index of every set bit, one per output handshake.
- Scan order is MSB-first or LSB-first, selected per transaction.
- Used by the accelerator control path wherever a sparse mask must be walked, e.g. active lanes, nonzero operands or pending requests.

Parameters:
- WIDTH, 32, input vector width; power of two, >= 2.
- IDX_W, $clog2(WIDTH), index width; derived, not overridden.
- SEQ_W, $clog2(WIDTH)+1, beat-counter width; derived.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous abort of the current transaction.
- in_vld  in  1  input vector valid.
- in_rdy  out  1  block can accept a vector.
- in_vec  in  WIDTH  vector to scan.
- in_lsb_first  in  1  0 = MSB-first scan, 1 = LSB-first scan; sampled on accept.
- out_vld  out  1  output beat valid.
- out_rdy  in  1  consumer accepts beat.
- out_idx  out  IDX_W  bit index of the current set bit.
- out_seq  out  SEQ_W  beat number within the transaction, starting at 0.
- out_last  out  1  final beat of the transaction.
- out_zero  out  1  input vector was all zeros; only beat of the transaction.
- busy  out  1  transaction in progress.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state = IDLE; residual = 0; dir = 0; out_seq = 0; zero flag = 0.
  - out_vld = 0, busy = 0.
  - in_rdy = 0 while rst is high; in_rdy = 1 on the first cycle after rst falls.
- FSM has two states, IDLE and SCAN.
- IDLE:
  - in_rdy = 1.
  - On in_vld & in_rdy: residual <= in_vec; dir <= in_lsb_first; out_seq <= 0; zero flag <= (in_vec == 0); go to SCAN.
- SCAN:
  - out_vld = 1.
  - out_idx = priority encode of residual: highest set bit if dir = 0, lowest set bit if dir = 1.
  - out_last = (residual has at most one bit set).
  - out_zero = zero flag. When out_zero = 1: out_idx = 0, out_last = 1.
  - On out_vld & out_rdy with !out_last: clear bit out_idx in residual; out_seq <= out_seq + 1.
  - On out_vld & out_rdy with out_last: go to IDLE.
- Latency:
  - First beat is valid the cycle after input accept; no combinational in-to-out path.
  - One beat per cycle while out_rdy = 1. N set bits take N cycles; an all-zero vector takes 1 beat.
- Back-to-back: in_rdy is also 1 in SCAN during the cycle out_vld & out_rdy & out_last. A new vector accepted that cycle loads directly and stays in SCAN, giving zero bubble between transactions.
- Backpressure: while out_rdy = 0, out_idx, out_seq, out_last and out_zero hold stable.
- in_lsb_first and in_vec are ignored except on the accept cycle.
- busy = (state == SCAN).
- flush:
  - Forces IDLE and clears residual next cycle.
  - Any in-flight beat is dropped; out_vld = 0 the next cycle.
  - flush has priority over accept and over the out handshake in the same cycle.
  - in_rdy = 0 during a flush cycle.
- rst has priority over flush.
- Width rules: out_seq never exceeds WIDTH-1. With all WIDTH bits set, the last beat has out_seq = WIDTH-1.
- Boundaries:
  - Bits 0 and WIDTH-1 scan correctly in both orders.
  - A single-bit vector produces exactly one beat with out_last = 1 and out_zero = 0.

Decomposition:
- Shared package bit_scan_pkg holds:
  - scan-direction constants SCAN_MSB_FIRST = 0 and SCAN_LSB_FIRST = 1;
  - FSM state enum IDLE/SCAN;
  - a function computing SEQ_W from WIDTH.
- One sub-module, prio_enc_param: a combinational parametrised priority encoder.
  - Inputs: vec[WIDTH], dir.
  - Outputs: idx[IDX_W], any, onehot_or_zero.
  - Written as a for-loop, replacing the hand-enumerated 32-case table.
  - Instantiated once on residual.

Test Plan:
1. WIDTH=32, in_vec=32'h8000_0001, in_lsb_first=0, out_rdy=1 -> beats (idx 31, seq 0, last 0), then (idx 0, seq 1, last 1); in_rdy high the cycle of the last beat.
2. Same vector with in_lsb_first=1 -> idx 0 then idx 31; out_seq 0, 1.
3. in_vec=0 -> single beat with out_zero=1, out_last=1, out_idx=0, out_seq=0; back to IDLE next cycle.
4. in_vec=32'hFFFF_FFFF, MSB-first, out_rdy toggling 1/0 each cycle -> 32 beats, idx 31 down to 0, outputs stable during out_rdy=0, final out_seq=31.
5. Back-to-back: 32'h0000_0030 then 32'h0000_0100, both held valid -> beats 5, 4, 8 on consecutive out_rdy cycles, no bubble.
6. Assert flush after the first beat of 32'h0F00_0000; separately assert rst mid-SCAN -> out_vld=0 the next cycle and in_rdy=1 after; a new vector 32'h0000_0002 then yields exactly idx 1 with last=1.
